logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, registered bitwise logic unit; successor of the fixed 32-bit inverter.
//  Performs one of eight bitwise ops on two WIDTH-bit operands.
//  Input and output are valid/ready handshakes. A 2-entry output buffer absorbs backpressure.
//  Sits in the ALU logic slice between the operand muxes and the result mux.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=1)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B (ignored by NOT A and PASS A)
//  in_op      in   3      op select, see BEHAVIOUR
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result this cycle
//  out_y      out  WIDTH  result
//  out_zero   out  1      1 when out_y == 0
// BEHAVIOUR
//  - One clock. Reset is asynchronous and active-high.
//  - Reset values: out_valid=0, out_y=0, out_zero=0, in_ready=1, count=0.
//  - Op encoding (bitwise, all WIDTH bits):
//    000 ~A   001 A&B   010 A|B   011 A^B   100 ~(A|B)   101 ~(A&B)   110 ~(A^B)   111 A
//  - All codes are defined. There is no error path.
//  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
//  - Result and zero flag are computed combinationally at push and stored in the buffer.
//  - Latency: a beat pushed at edge N is visible on out_* from edge N.
//    This applies when the buffer was empty or the head pops at edge N. Otherwise the beat waits in FIFO order.
//  - Buffer state machine on count:
//    EMPTY(0) -> ONE on push
//    ONE(1)   -> EMPTY on pop without push
//    ONE(1)   -> TWO on push without pop
//    ONE(1)   -> stays ONE on push & pop: the new beat becomes head
//    TWO(2)   -> ONE on pop. No push is possible in TWO.
//  - in_ready = (count != 2), driven from a register with no combinational path from out_ready.
//    Consequence: after a pop from TWO, in_ready rises one cycle later.
//  - out_valid = (count != 0). out_y/out_zero always show the head entry.
//  - The head holds stable while out_valid=1 and out_ready=0. Data never changes under a stalled beat.
//  - When count=0, out_y and out_zero hold 0.
//  - in_valid with in_ready=0 is ignored. The source must hold the beat; no data is lost or duplicated.
//  - Reset asserted mid-operation discards all buffered beats immediately, asynchronously.
//    Outputs return to their reset values. The first push after deassertion is accepted normally.
//  - No X propagation: an unused buffer entry is never driven to out_*.
// TESTING (WIDTH=32 unless stated)
//  1. Reset then push A=0x0000FFFF op=000, out_ready=1 -> next edge out_y=0xFFFF0000, out_zero=0, out_valid 1 cycle.
//  2. All ops with A=0xF0F0F0F0, B=0xFF00FF00 ->
//     000:0F0F0F0F  001:F000F000  010:FFF0FFF0  011:0FF00FF0
//     100:000F000F  101:0FFF0FFF  110:F00FF00F  111:F0F0F0F0
//  3. Zero flag: A=B=0x12345678, op=011 -> out_y=0, out_zero=1.
//     Then op=000, A=0xFFFFFFFF -> out_zero=1.
//  4. Backpressure: out_ready=0, push 3 beats (ops 001,010,011) -> only 2 accepted, in_ready=0.
//     Raise out_ready -> results appear in push order. The third beat is accepted once in_ready returns 1.
//  5. Simultaneous push/pop at count=1 with out_ready=1, in_valid=1 each cycle for 10 beats
//     -> one result per cycle, in order, in_ready stays 1.
//  6. Assert reset with count=2 mid-cycle -> out_valid=0, out_y=0, in_ready=1 immediately.
//     After release, push A=0x1 op=111 -> out_y=0x00000001. Repeat case 2 with WIDTH=8 (truncated values).

Source files
------------

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered eight-op bitwise logic unit
// with valid/ready handshakes and a 2-entry output buffer.
module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       count, count_nxt;
  logic [WIDTH-1:0] res, head_y, tail_y;
  logic             res_z, head_z, tail_z;
  logic             push, pop;

  always_comb begin
    res = '0;
    case (in_op)
      3'b000:  res = ~in_a;
      3'b001:  res = in_a & in_b;
      3'b010:  res = in_a | in_b;
      3'b011:  res = in_a ^ in_b;
      3'b100:  res = ~(in_a | in_b);
      3'b101:  res = ~(in_a & in_b);
      3'b110:  res = ~(in_a ^ in_b);
      default: res = in_a;
    endcase
  end

  assign res_z = (res == '0);
  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= EMPTY;
    else       count <= count_nxt;
  end

  always_comb begin
    count_nxt = count;
    case (count)
      EMPTY:   if (push) count_nxt = ONE;
      ONE:     if (pop && !push) count_nxt = EMPTY;
               else if (push && !pop) count_nxt = TWO;
      TWO:     if (pop) count_nxt = ONE;
      default: count_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (count != EMPTY);
  end

  // Registered ready keeps out_ready off the in_ready path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_ready <= 1'b1;
    else       in_ready <= (count_nxt != TWO);
  end

  // Head is zeroed whenever the buffer drains, so an empty unit shows 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_y <= '0;
      head_z <= 1'b0;
      tail_y <= '0;
      tail_z <= 1'b0;
    end else if (pop && count == TWO) begin
      head_y <= tail_y;
      head_z <= tail_z;
      tail_y <= '0;
      tail_z <= 1'b0;
    end else if (push && (count == EMPTY || pop)) begin
      head_y <= res;
      head_z <= res_z;
    end else if (push) begin
      tail_y <= res;
      tail_z <= res_z;
    end else if (pop) begin
      head_y <= '0;
      head_z <= 1'b0;
    end
  end

  assign out_y    = head_y;
  assign out_zero = head_z;

endmodule
